// File: rtl/dt_pkg.sv
// Shared definitions for the PE1 Dadda-tree stages: default widths and the redundant pair type.
`default_nettype none

package dt_pkg;

  localparam int PE1_TREE_W    = 15;
  localparam int PE1_CPA_SPLIT = 8;

  typedef struct packed {
    logic [PE1_TREE_W-1:0] s;
    logic [PE1_TREE_W-1:0] c;
  } dt_pair_t;

endpackage

`default_nettype wire

// File: rtl/cpa_slice.sv
// N-bit ripple adder slice with carry-in; the MSB of the result is the carry-out.
`default_nettype none

module cpa_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

`default_nettype wire

// File: rtl/dt3_cpa.sv
// Two-stage split carry-propagate adder closing the dt3 reduction tree; valid/ready on both sides.
`default_nettype none

module dt3_cpa
  import dt_pkg::*;
#(
  parameter int W     = PE1_TREE_W,
  parameter int SPLIT = PE1_CPA_SPLIT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int HW = W - SPLIT;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [SPLIT:0]   low_q;
  logic [SPLIT:0]   low_d;
  logic [HW-1:0]    shi_q, chi_q;
  logic [HW:0]      hi_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             adv2;
  logic             accept;

  cpa_slice #(.N(SPLIT)) u_lo (
    .a_i   (s_in[SPLIT-1:0]),
    .b_i   (c_in[SPLIT-1:0]),
    .cin_i (1'b0),
    .sum_o (low_d)
  );

  cpa_slice #(.N(HW)) u_hi (
    .a_i   (shi_q),
    .b_i   (chi_q),
    .cin_i (low_q[SPLIT]),
    .sum_o (hi_d)
  );

  assign sum_d  = {hi_d[HW-1:0], low_q[SPLIT-1:0]};
  assign cout_d = hi_d[HW];

  // in_ready depends on out_ready only, never on in_valid.
  always_comb begin
    adv2     = v1_q & (~v2_q | out_ready);
    in_ready = ~v1_q | adv2;
    accept   = in_valid & in_ready;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (accept) begin
      v1_d = 1'b1;
    end else if (adv2) begin
      v1_d = 1'b0;
    end
    if (adv2) begin
      v2_d = 1'b1;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      low_q  <= '0;
      shi_q  <= '0;
      chi_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (accept) begin
        low_q <= low_d;
        shi_q <= s_in[W-1:SPLIT];
        chi_q <= c_in[W-1:SPLIT];
      end
      if (adv2) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_dt3_cpa.sv
// Scoreboard bench for dt3_cpa: directed vectors, backpressure, async reset and random traffic.
`default_nettype none

module tb_dt3_cpa;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] s_in, c_in;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] sum;
  logic        cout;

  typedef struct {
    logic [14:0] sum;
    logic        cout;
    int          cyc;
  } item_t;

  item_t sq[$];
  int    n_cmp   = 0;
  int    n_err   = 0;
  int    cyc     = 0;
  bit    lat_chk = 1'b0;
  bit    rdy_rand = 1'b0;

  dt3_cpa dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when out_valid & out_ready now.
  bit          prev_hold = 1'b0;
  logic [15:0] prev_out;
  always begin
    @(negedge clk);
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) chk("hold_stable", {16'd0, cout, sum}, {16'd0, prev_out});
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got sum 0x%0h cout %0b, expected no output", sum, cout);
        end else begin
          item_t it;
          it = sq.pop_front();
          chk("result", {16'd0, cout, sum}, {16'd0, it.cout, it.sum});
          if (lat_chk) chk("latency", cyc - it.cyc, 32'd2);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {cout, sum};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [14:0] s, input logic [14:0] c,
                      input logic [14:0] es, input logic ec);
    bit    acc;
    item_t it;
    in_valid = 1'b1;
    s_in     = s;
    c_in     = c;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        it.sum = es; it.cout = ec; it.cyc = cyc;
        sq.push_back(it);
      end
      step();
      if (acc) return;
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1");
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (sq.size() == 0) return;
      step();
    end
    n_cmp++; n_err++;
    $display("FAIL drain_timeout: %0d results outstanding, expected 0", sq.size());
  endtask

  initial begin
    logic [31:0] r;
    logic [14:0] rs, rc;
    logic [15:0] t;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    s_in      = '0;
    c_in      = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {17'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // Directed arithmetic with latency checking.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(15'h00FF, 15'h0001, 15'h0100, 1'b0);
    send(15'h7FFF, 15'h0001, 15'h0000, 1'b1);
    send(15'h1234, 15'h0000, 15'h1234, 1'b0);
    idle(3);
    for (int k = 1; k <= 8; k++) send(15'(k), 15'(3 * k), 15'(4 * k), 1'b0);
    idle(1);
    drain();

    // Backpressure: two pairs fill the pipe, the third must wait.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(15'h0010, 15'h0001, 15'h0011, 1'b0);
    send(15'h0020, 15'h0002, 15'h0022, 1'b0);
    s_in = 15'h0030; c_in = 15'h0003; in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {17'd0, sum}, 32'h11);
      step();
    end
    out_ready = 1'b1;
    send(15'h0030, 15'h0003, 15'h0033, 1'b0);
    idle(1);
    drain();

    // Asynchronous reset with two pairs in flight.
    out_ready = 1'b0;
    send(15'h0100, 15'h0200, 15'h0300, 1'b0);
    send(15'h0400, 15'h0500, 15'h0900, 1'b0);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {17'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    sq.delete();
    #2 reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
    end
    step();

    // Random traffic against the arithmetic model.
    rdy_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      idle(int'($urandom_range(0, 2)));
      r  = $urandom; rs = r[14:0];
      r  = $urandom; rc = r[14:0];
      t  = {1'b0, rs} + {1'b0, rc};
      send(rs, rc, t[14:0], t[15]);
    end
    idle(1);
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dt3_cpa.md
Name: dt3_cpa

Overview:
- Final carry-propagate stage directly downstream of the level-3 Dadda reduction tree (dt3) in the PE1 modular multiplier datapath.
- Consumes the redundant sum/carry vector pair the tree emits and produces one binary word per transaction.
- Two-stage pipelined split adder with valid/ready handshake, so the combinational tree output is registered before the reduction logic that follows.

Parameters:
- W, 15, operand/result width; matches the dt3 s/c width.
- SPLIT, 8, width of the low slice added in stage 1; the high slice (W-SPLIT bits) is added in stage 2. Legal range 1..W-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  s_in/c_in hold a valid pair.
- in_ready  out  1  stage 1 can accept this cycle.
- s_in  in  W  sum vector from dt3 (s).
- c_in  in  W  carry vector from dt3 (c), already bit-aligned with s_in.
- out_valid  out  1  sum/cout hold a valid result.
- out_ready  in  1  downstream accepts this cycle.
- sum  out  W  (s_in + c_in) mod 2^W.
- cout  out  1  carry out of bit W-1; dt3 discards its top carry, and cout reports it for debug and assertions.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): v1 = v2 = 0, all data registers = 0, so out_valid = 0, sum = 0, cout = 0.
- Reset mid-operation drops all in-flight pairs. No partial result is ever presented.
- Stage 1 on accept:
  - low = s_in[SPLIT-1:0] + c_in[SPLIT-1:0], registered as SPLIT+1 bits (carry kept).
  - s_in[W-1:SPLIT] and c_in[W-1:SPLIT] registered unchanged.
  - v1 <= 1.
- Stage 2 on advance:
  - hi = s_hi + c_hi + low[SPLIT], width W-SPLIT+1.
  - sum <= {hi[W-SPLIT-1:0], low[SPLIT-1:0]}; cout <= hi[W-SPLIT]; v2 <= 1.
- Latency: a pair accepted in cycle N is presented in cycle N+2 if out_ready is held high.
- Throughput: 1 pair per cycle.
- Handshake:
  - Transfer on input occurs when in_valid & in_ready; transfer on output occurs when out_valid & out_ready.
  - adv2 = v1 & (~v2 | out_ready).
  - in_ready = ~v1 | adv2. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - out_valid = v2; sum and cout stay stable while out_valid & ~out_ready.
  - When stage 2 empties without refill (out_ready & ~adv2), v2 <= 0. Data registers may hold stale values.
  - When stage 1 advances without a new accept, v1 <= 0.
- Full condition: v1 & v2 & ~out_ready gives in_ready = 0, and the pipeline holds two pairs.
- Simultaneous events: output pop, stage advance and input accept all in the same cycle are legal and lossless, and order is preserved.
- Arithmetic wraps mod 2^W with no saturation. cout = 1 exactly when s_in + c_in >= 2^W.

Decomposition:
- Shared package dt_pkg holds:
  - PE1_TREE_W = 15 (default for W)
  - PE1_CPA_SPLIT = 8
  - a typedef for the W-bit redundant pair {s, c}, reused by all dt* stages.
- One sub-module, cpa_slice: parameterised N-bit adder with carry-in, returning an N+1-bit result.
  - Instantiated once per stage: N = SPLIT with cin = 0, and N = W-SPLIT with cin = the registered low carry.

Test Plan:
- Intra-slice carry: s_in=0x00FF, c_in=0x0001, out_ready=1 -> two cycles later sum=0x0100, cout=0.
- Full wrap: s_in=0x7FFF, c_in=0x0001 -> sum=0x0000, cout=1. Also s_in=0x1234, c_in=0x0000 -> sum=0x1234, cout=0.
- Streaming: in_valid=1 for 8 consecutive cycles with pairs (k, 3k), k=1..8, out_ready=1 -> out_valid high for 8 consecutive cycles starting 2 cycles later, with sum=4k in order.
- Backpressure: out_ready=0, offer 3 pairs (0x0010,0x0001), (0x0020,0x0002), (0x0030,0x0003):
  - first 2 accepted; in_ready=0 on the third.
  - sum held at 0x0011 until out_ready=1.
  - then outputs 0x0011, 0x0022, 0x0033 in order, with no loss or duplicate.
- Reset mid-operation: two pairs in flight, pulse reset_n low asynchronously mid-cycle -> out_valid=0 and sum=0 immediately. After release, in_ready=1, and no stale result is ever presented.
- Randomised check against a reference model: 10k random (s_in, c_in) pairs with random in_valid/out_ready -> each output equals (s+c) mod 2^15 with cout = bit 15, and transaction order is preserved.
